// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and defaults for the CPU data-memory interface
//   mem_rsp_state_t : responder FSM states
//   mem_req_t       : one latched request (write, addr, wdata, wstrb)
package mem_if_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_rsp_state_t;
   localparam int DEFAULT_DEPTH = 32;
   localparam int DEFAULT_LATENCY = 2;
   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: replace the byte lanes of a word selected by a strobe
//   i_old   : current word
//   i_wdata : store data, lanes aligned to the word
//   i_wstrb : bit i selects wdata bits [8i+7:8i]
//   o_word  : merged word
module byte_lane_merge (
   input  logic [31:0] i_old,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic [31:0] o_word
);
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign o_word[8*i+:8] = i_wstrb[i] ? i_wdata[8*i+:8] : i_old[8*i+:8];
   end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency word memory behind valid/ready request/response channels
//   clk, reset            : clock, synchronous active-high reset
//   req_*                 : request channel (write, byte addr, wdata, wstrb)
//   rsp_*                 : response channel (rdata, error)
//   initial_values        : contents loaded during reset, word i at [32i+31:32i]
//   memory_check          : live view of the array, same packing
module data_memory_responder
   import mem_if_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   input  logic [3:0]          req_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_error,
   input  logic [32*DEPTH-1:0] initial_values,
   output logic [32*DEPTH-1:0] memory_check
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(LATENCY + 1);
   if (LATENCY < 1) begin : g_bad_latency
      $error("data_memory_responder: LATENCY must be at least 1");
   end
   mem_rsp_state_t r_state;
   logic [CW-1:0]  r_cnt;
   mem_req_t       r_req;
   logic [31:0]    r_rdata;
   logic           r_error;
   logic [31:0]    r_mem [DEPTH];
   mem_req_t       w_in;
   mem_req_t       w_req;
   logic           w_access;
   logic           w_err;
   logic [AW-1:0]  w_idx;
   logic [31:0]    w_merged;
   assign w_in = '{req_write, req_addr, req_wdata, req_wstrb};
   // With LATENCY=1 the access edge is the acceptance edge, so execute straight from the inputs.
   assign w_req = (r_state == IDLE) ? w_in : r_req;
   assign w_access = (r_state == IDLE && req_valid && LATENCY == 1) || (r_state == WAIT && r_cnt == '0);
   assign w_err = (w_req.addr[1:0] != 2'b00) || (w_req.addr[31:2] >= 30'(DEPTH));
   assign w_idx = w_req.addr[AW+1:2];
   assign req_ready = (r_state == IDLE) && !reset;
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_error = r_error;
   byte_lane_merge u_merge (
      .i_old  (r_mem[w_idx]),
      .i_wdata(w_req.wdata),
      .i_wstrb(w_req.wstrb),
      .o_word (w_merged)
   );
   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign memory_check[32*i+:32] = r_mem[i];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_req <= '0;
         r_rdata <= '0;
         r_error <= 1'b0;
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= initial_values[32*k+:32];
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_req <= w_in;
               r_cnt <= (LATENCY == 1) ? '0 : CW'(LATENCY - 2);
               r_state <= (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else r_state <= RESP;
            end
            RESP: if (rsp_ready) begin
               r_state <= IDLE;
               r_rdata <= '0;
               r_error <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
         if (w_access) begin
            r_error <= w_err;
            r_rdata <= (w_err || w_req.write) ? '0 : r_mem[w_idx];
            if (w_req.write && !w_err) r_mem[w_idx] <= w_merged;
         end
      end
   end
endmodule
